bus_arbiter8: RTL and testbench
===============================

// Module: bus_arbiter8
// PURPOSE
//  Round-robin arbiter sharing one 16-bit bus among 8 requesters.
//  Produces the 3-bit select for a Mux8Way16 (data path to the bus) and a Dmux8Way (per-beat ack back to the owner).
//  Grants are held for a burst, capped by MAX_HOLD beats for fairness.
//  Sits between the 8 requesting units and the single shared bus consumer.
// PARAMETERS
//  MAX_HOLD   4   max beats per grant; 0 = unlimited (release only on req drop)
// PORTS
//  clock      in   1    single clock; all state updates on rising edge
//  reset_n    in   1    asynchronous, active-low reset
//  req        in   8    req[i]: requester i wants the bus; held high for the whole burst
//  data_in    in   128  requester i data at [16*i+15:16*i]
//  bus_ready  in   1    consumer accepts the current beat this cycle
//  gnt        out  8    one-hot grant (registered); all-zero when idle
//  sel        out  3    index of current owner (registered); drives mux/demux selects
//  bus_data   out  16   data_in word of the owner, via Mux8Way16 on sel
//  bus_valid  out  1    gnt!=0 && req[sel]; combinational
//  ack        out  8    ack[i] = gnt[i] & bus_valid & bus_ready, via Dmux8Way; one beat transferred
//  busy       out  1    state==BUSY
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - state=IDLE, gnt=0, sel=0, beat_cnt=0, last=7, so requester 0 has priority first.
//    - Asserting reset mid-burst clears everything immediately; no partial ack is generated after.
//  - IDLE, req==0: stay IDLE, outputs quiet.
//  - IDLE, req!=0:
//    - next edge: pick the first i with req[i] set, scanning last+1, last+2, ... mod 8 (wrap 7->0).
//    - Load gnt=1<<i, sel=i, beat_cnt=0; go BUSY.
//    - Latency req->gnt = 1 cycle.
//  - BUSY:
//    - A beat completes on a cycle with bus_valid & bus_ready; ack[sel] is 1 that cycle only.
//    - Release at the edge when either:
//      (a) req[sel]==0 (no beat that cycle), or
//      (b) a beat completes and MAX_HOLD!=0 and beat_cnt==MAX_HOLD-1.
//    - Otherwise, on a completed beat, beat_cnt++.
//    - On release: last=sel, gnt=0, beat_cnt=0, sel holds its value; go IDLE.
//  - Exactly one dead (IDLE) cycle between consecutive grants, even with requests pending.
//    - Worst-case wait for any requester: 7*(MAX_HOLD+1)+1 cycles with ready always high.
//  - bus_ready low stalls: beat_cnt is unchanged, the grant is kept, no ack.
//  - Requests from non-owners during BUSY are ignored until the next IDLE pick.
//  - Owner drops req and re-raises it later: it is treated as a new request; round-robin puts it behind the others.
//  - gnt is always one-hot or zero; ack is always a subset of gnt.
//  - beat_cnt width = $clog2(MAX_HOLD+1), minimum 1.
// STRUCTURE
//  - Shared package (arb_pkg):
//    - localparams ST_IDLE=1'b0 and ST_BUSY=1'b1;
//    - N_REQ=8 and SEL_W=3.
//  - Sub-module rr_pick8(req[7:0], last[2:0] -> idx[2:0], any):
//    - combinational rotate, priority encode, un-rotate.
//  - Instantiates the existing Mux8Way16 for bus_data and Dmux8Way for ack;
//    - the Dmux8Way input is bus_valid & bus_ready.
// TESTING
//  1. Reset then req=8'h01, bus_ready=1, hold req:
//     - gnt=8'h01 one cycle later;
//     - ack[0] pulses 4 cycles;
//     - gnt=0 for 1 cycle;
//     - re-grant to 0.
//  2. req=8'hFF held, bus_ready=1, MAX_HOLD=4:
//     - grant order 0,1,...,7,0;
//     - each owner gets exactly 4 acks; 5-cycle period per owner.
//  3. Owner 3 with bus_ready=0 for 10 cycles, then 1:
//     - gnt stays 8'h08 with no ack while stalled;
//     - then 4 acks; bus_data == data_in[63:48] throughout.
//  4. Owner 5 drops req after 2 acks:
//     - release at the next edge; last=5;
//     - with req=8'h21 pending, next grant goes to 0, not 5.
//  5. Assert reset_n=0 mid-burst (asynchronous, between edges):
//     - gnt, ack, busy go 0 immediately;
//     - after release, requester 0 has priority again.
//  6. MAX_HOLD=0 build, req=8'h06:
//     - requester 1 keeps the grant for 20 beats until its req drops;
//     - then requester 2 is granted after one idle cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter.
// State encodings and requester/select widths live here so every file agrees.
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   typedef enum logic {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY
   } arb_state_e;

endpackage

// File: rtl/Dmux8Way.sv
// One-bit demultiplexer: routes in_i to output sel_i, all other outputs low.
module Dmux8Way (
   input  logic       in_i,
   input  logic [2:0] sel_i,
   output logic [7:0] out_o
);

   always_comb begin
      out_o        = '0;
      out_o[sel_i] = in_i;
   end

endmodule

// File: rtl/Mux8Way16.sv
// Eight-input, 16-bit wide word selector; input word i sits at data_i[16*i+15:16*i].
module Mux8Way16 (
   input  logic [127:0] data_i,
   input  logic [2:0]   sel_i,
   output logic [15:0]  out_o
);

   assign out_o = data_i[{sel_i, 4'b0000} +: 16];

endmodule

// File: rtl/bus_arbiter8_rr_pick8.sv
// Round-robin pick: the first set request scanning last+1, last+2, ... with wrap.
// Implemented as rotate, priority encode, then un-rotate by adding the offset back.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [SEL_W-1:0] last_i,
   output logic [SEL_W-1:0] idx_o,
   output logic             any_o
);

   logic [2*N_REQ-1:0] doubled;
   logic [N_REQ-1:0]   rotated;
   logic [SEL_W-1:0]   offset;

   always_comb begin
      doubled = {req_i, req_i};
      // rotated[k] is the request of requester (last+1+k) mod 8
      rotated = doubled[{1'b0, last_i} + 4'd1 +: N_REQ];
      offset  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            offset = SEL_W'(i);
         end
      end
      idx_o = last_i + SEL_W'(1) + offset;
      any_o = |req_i;
   end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter sharing one 16-bit bus among 8 requesters, with bursts
// capped at MAX_HOLD beats (0 = unlimited) and one idle cycle between grants.
module bus_arbiter8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [16*N_REQ-1:0] data_in,
   input  logic                bus_ready,
   output logic [N_REQ-1:0]    gnt,
   output logic [SEL_W-1:0]    sel,
   output logic [15:0]         bus_data,
   output logic                bus_valid,
   output logic [N_REQ-1:0]    ack,
   output logic                busy
);

   localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic HOLD_CAPPED = (MAX_HOLD != 0);

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [SEL_W-1:0] pickIdx;
   logic             pickAny;
   logic             beat;
   logic             holdDone;

   rr_pick8 u_pick (
      .req_i  (req),
      .last_i (last_q),
      .idx_o  (pickIdx),
      .any_o  (pickAny)
   );

   assign bus_valid = (|gnt_q) & req[sel_q];
   assign beat      = bus_valid & bus_ready;
   assign holdDone  = HOLD_CAPPED && (cnt_q == LAST_BEAT);

   // last resets to 7 so requester 0 wins the very first pick
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= SEL_W'(N_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pickAny) begin
               state_d = BUSY;
               gnt_d   = {{(N_REQ - 1){1'b0}}, 1'b1} << pickIdx;
               sel_d   = pickIdx;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            // Release on owner dropping req or on the final capped beat; sel is kept
            if (!req[sel_q] || (beat && holdDone)) begin
               state_d = IDLE;
               gnt_d   = '0;
               last_d  = sel_q;
               cnt_d   = '0;
            end else if (beat) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = (state_q == BUSY);

   Mux8Way16 u_mux (
      .data_i (data_in),
      .sel_i  (sel_q),
      .out_o  (bus_data)
   );

   Dmux8Way u_dmux (
      .in_i  (beat),
      .sel_i (sel_q),
      .out_o (ack)
   );

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8: expected ack owners are queued by the stimulus
// and popped by per-instance monitors; a MAX_HOLD=0 instance covers unlimited bursts.
module tb_bus_arbiter8;

   logic         clock;
   logic         reset_n;
   logic [127:0] dataIn;

   logic [7:0]   reqA, gntA, ackA;
   logic         readyA, busValidA, busyA;
   logic [2:0]   selA;
   logic [15:0]  busDataA;

   logic [7:0]   reqB, gntB, ackB;
   logic         readyB, busValidB, busyB;
   logic [2:0]   selB;
   logic [15:0]  busDataB;

   logic [15:0]  words [8];
   int           qA[$];
   int           qB[$];
   int           total;
   int           bad;
   int           ownA;
   int           ownB;

   bus_arbiter8 #(.MAX_HOLD(4)) dutA (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (reqA),
      .data_in   (dataIn),
      .bus_ready (readyA),
      .gnt       (gntA),
      .sel       (selA),
      .bus_data  (busDataA),
      .bus_valid (busValidA),
      .ack       (ackA),
      .busy      (busyA)
   );

   bus_arbiter8 #(.MAX_HOLD(0)) dutB (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (reqB),
      .data_in   (dataIn),
      .bus_ready (readyB),
      .gnt       (gntB),
      .sel       (selB),
      .bus_data  (busDataB),
      .bus_valid (busValidB),
      .ack       (ackB),
      .busy      (busyB)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] reqVal, input logic readyVal);
      reqA   = reqVal;
      readyA = readyVal;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic applyReset();
      reset_n = 1'b0;
      applyStimulus(8'h00, 1'b0);
      reqB   = 8'h00;
      readyB = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic pushA(input int owner, input int beats);
      for (int i = 0; i < beats; i++) qA.push_back(owner);
   endtask

   // Monitors compare every acked beat against the queued owner
   always @(negedge clock) begin
      if (reset_n) begin
         checkOutput("A gnt onehot0", 32'($countones(gntA) <= 1), 32'd1);
         checkOutput("A ack within gnt", 32'(ackA & ~gntA), 32'd0);
         if (ackA != 8'h00) begin
            if (qA.size() == 0) begin
               checkOutput("A unexpected ack", 32'(ackA), 32'd0);
            end else begin
               ownA = qA.pop_front();
               checkOutput("A ack owner", 32'(ackA), 32'(8'h01 << ownA));
               checkOutput("A sel", 32'(selA), 32'(ownA));
               checkOutput("A bus_data", 32'(busDataA), 32'(words[ownA]));
            end
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n && ackB != 8'h00) begin
         if (qB.size() == 0) begin
            checkOutput("B unexpected ack", 32'(ackB), 32'd0);
         end else begin
            ownB = qB.pop_front();
            checkOutput("B ack owner", 32'(ackB), 32'(8'h01 << ownB));
            checkOutput("B bus_data", 32'(busDataB), 32'(words[ownB]));
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      words = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, 16'hE4E4, 16'hF5F5, 16'h1616, 16'h2727};
      for (int i = 0; i < 8; i++) dataIn[16*i +: 16] = words[i];

      // Reset state, then a single held requester: 4 acks, 1 dead cycle, re-grant
      applyReset();
      checkOutput("reset gnt", 32'(gntA), 32'h00);
      checkOutput("reset sel", 32'(selA), 32'd0);
      checkOutput("reset busy", 32'(busyA), 32'd0);
      checkOutput("reset ack", 32'(ackA), 32'h00);
      checkOutput("reset bus_valid", 32'(busValidA), 32'd0);
      applyStimulus(8'h01, 1'b1);
      pushA(0, 8);
      checkOutput("no grant before edge", 32'(gntA), 32'h00);
      waitEdges(1);
      checkOutput("t1 gnt latency", 32'(gntA), 32'h01);
      waitEdges(4);
      checkOutput("t1 dead gnt", 32'(gntA), 32'h00);
      checkOutput("t1 dead busy", 32'(busyA), 32'd0);
      checkOutput("t1 sel held", 32'(selA), 32'd0);
      waitEdges(1);
      checkOutput("t1 regrant", 32'(gntA), 32'h01);
      waitEdges(4);
      applyStimulus(8'h00, 1'b1);
      waitEdges(2);
      checkOutput("t1 idle", 32'(gntA), 32'h00);

      // All requesting: order 0..7,0 with a 5-cycle period
      applyReset();
      applyStimulus(8'hFF, 1'b1);
      for (int k = 0; k < 9; k++) pushA(k % 8, 4);
      waitEdges(1);
      for (int k = 0; k < 9; k++) begin
         checkOutput("t2 rr grant", 32'(gntA), 32'(8'h01 << (k % 8)));
         waitEdges(4);
         checkOutput("t2 dead cycle", 32'(gntA), 32'h00);
         if (k < 8) waitEdges(1);
      end
      applyStimulus(8'h00, 1'b1);
      waitEdges(2);

      // Owner 3 stalled by bus_ready for 10 cycles, then 4 beats
      applyReset();
      applyStimulus(8'h08, 1'b0);
      for (int k = 0; k < 10; k++) begin
         waitEdges(1);
         checkOutput("t3 stall gnt", 32'(gntA), 32'h08);
         checkOutput("t3 stall ack", 32'(ackA), 32'h00);
         checkOutput("t3 stall data", 32'(busDataA), 32'(words[3]));
      end
      pushA(3, 4);
      waitEdges(1);
      applyStimulus(8'h08, 1'b1);
      waitEdges(4);
      applyStimulus(8'h00, 1'b1);
      checkOutput("t3 released", 32'(gntA), 32'h00);
      waitEdges(1);

      // Owner 5 drops after 2 beats; re-raised request goes behind requester 0
      applyReset();
      applyStimulus(8'h20, 1'b1);
      pushA(5, 2);
      waitEdges(1);
      checkOutput("t4 gnt 5", 32'(gntA), 32'h20);
      waitEdges(2);
      applyStimulus(8'h01, 1'b1);
      pushA(0, 4);
      waitEdges(1);
      checkOutput("t4 drop release", 32'(gntA), 32'h00);
      applyStimulus(8'h21, 1'b1);
      waitEdges(1);
      checkOutput("t4 next is 0", 32'(gntA), 32'h01);
      waitEdges(4);
      applyStimulus(8'h00, 1'b1);
      waitEdges(2);

      // Asynchronous reset in the middle of a burst
      applyReset();
      applyStimulus(8'h01, 1'b1);
      pushA(0, 2);
      waitEdges(3);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("t5 async gnt", 32'(gntA), 32'h00);
      checkOutput("t5 async ack", 32'(ackA), 32'h00);
      checkOutput("t5 async busy", 32'(busyA), 32'd0);
      applyStimulus(8'h81, 1'b1);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      pushA(0, 4);
      waitEdges(1);
      checkOutput("t5 priority 0", 32'(gntA), 32'h01);
      waitEdges(4);
      applyStimulus(8'h00, 1'b1);
      waitEdges(2);
      checkOutput("t5 idle", 32'(gntA), 32'h00);

      // Unlimited hold: requester 1 keeps 20 beats, then 2 after one idle cycle
      applyReset();
      reqB   = 8'h06;
      readyB = 1'b1;
      for (int i = 0; i < 20; i++) qB.push_back(1);
      waitEdges(1);
      checkOutput("t6 gnt 1", 32'(gntB), 32'h02);
      waitEdges(19);
      checkOutput("t6 still 1", 32'(gntB), 32'h02);
      waitEdges(1);
      reqB = 8'h04;
      waitEdges(1);
      checkOutput("t6 idle gap", 32'(gntB), 32'h00);
      checkOutput("t6 idle busy", 32'(busyB), 32'd0);
      waitEdges(1);
      checkOutput("t6 gnt 2", 32'(gntB), 32'h04);
      reqB = 8'h00;
      waitEdges(2);
      checkOutput("t6 final idle", 32'(gntB), 32'h00);

      checkOutput("A queue drained", 32'(qA.size()), 32'd0);
      checkOutput("B queue drained", 32'(qB.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
